// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding and default word width for the multicycle CPU slice.
package cpu_pkg;
  localparam int WORD_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} mau_state_e;
endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: clear/enable cycle counter flagging the cycle whose edge reaches TIMEOUT_CYC.
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT_CYC) + 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
  assign tc = en && cnt == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns level-style CPU memory requests into a readM/writeM handshake with IR/MDR capture.
module mem_access_unit import cpu_pkg::*; #(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ir_write,
  input  logic              iord,
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] alu_out,
  input  logic [WORD_W-1:0] store_data,
  output logic              readM,
  output logic              writeM,
  output logic [WORD_W-1:0] address,
  output logic [WORD_W-1:0] m_wdata,
  input  logic [WORD_W-1:0] m_rdata,
  input  logic              inputReady,
  input  logic              ackOutput,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] mdr,
  output logic              busy,
  output logic              done,
  output logic              mem_err
);
  mau_state_e state, state_nxt;
  logic acc, rd_ok, wr_ok, tc, dest_ir;
  mem_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_cnt (
    .clk(clk), .reset_n(reset_n), .clr(acc), .en(readM || writeM), .tc(tc)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    acc       = state == IDLE && (mem_read || mem_write);
    rd_ok     = state == READ && inputReady;
    wr_ok     = state == WRITE && ackOutput;
    readM     = state == READ;
    writeM    = state == WRITE;
    done      = state == DONE;
    busy      = readM || writeM || acc;
    state_nxt = acc ? (mem_read ? READ : WRITE) :
                (rd_ok || wr_ok || tc || done) ? (done ? IDLE : DONE) : state;
  end
  // a response on the terminal-count edge wins over the timeout
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      address <= '0;
      m_wdata <= '0;
      dest_ir <= 1'b0;
      instr   <= '0;
      mdr     <= '0;
      mem_err <= 1'b0;
    end else begin
      if (acc) begin
        address <= iord ? alu_out : pc;
        m_wdata <= store_data;
        dest_ir <= ir_write;
      end
      if (rd_ok && dest_ir) instr <= m_rdata;
      if (rd_ok && !dest_ir) mdr <= m_rdata;
      if ((acc && mem_read && mem_write) || (tc && !rd_ok && !wr_ok)) mem_err <= 1'b1;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle memory front-end between the CPU control unit and the external single-port memory. It converts the control unit's level-style MemRead/MemWrite/IorD/IRWrite requests into the memory's readM/writeM handshake, and holds address and write data stable for the whole access. It captures returned data into the instruction register (IR) or memory data register (MDR), and raises `busy` so the control unit holds its state until the access completes.

## Interface
- WORD_W, 16, address/data width
- TIMEOUT_CYC, 255, max cycles waiting for inputReady/ackOutput before abort (≥1)

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset (one clock; reset asynchronous active-low)
- mem_read  in  1  read request (control unit MemRead)
- mem_write  in  1  write request (control unit MemWrite)
- ir_write  in  1  read destination: 1 = IR, 0 = MDR
- iord  in  1  address select: 0 = pc, 1 = alu_out
- pc  in  WORD_W  program counter
- alu_out  in  WORD_W  ALUOut register
- store_data  in  WORD_W  write data (B register)
- readM  out  1  memory read strobe
- writeM  out  1  memory write strobe
- address  out  WORD_W  memory address
- m_wdata  out  WORD_W  memory write data
- m_rdata  in  WORD_W  memory read data, valid with inputReady
- inputReady  in  1  read data valid
- ackOutput  in  1  write accepted
- instr  out  WORD_W  IR contents
- mdr  out  WORD_W  MDR contents
- busy  out  1  stall to control unit
- done  out  1  one-cycle completion pulse
- mem_err  out  1  sticky error: timeout or read+write conflict

## Operation
- States: IDLE, READ, WRITE, DONE.
- In IDLE, a request is accepted on the rising edge where mem_read or mem_write is high:
  - Latch address = iord ? alu_out : pc.
  - Latch m_wdata = store_data and the ir_write destination.
  - Clear the timeout counter.
  - Go to READ if mem_read is high, else WRITE.
- If mem_read and mem_write are both high, the read is performed, the write is dropped, and mem_err is set.
- READ: readM=1.
  - On the edge with inputReady=1, load m_rdata into IR (ir_write latched 1) or MDR (latched 0), then go to DONE.
- WRITE: writeM=1.
  - On the edge with ackOutput=1, go to DONE.
- Timeout: in READ/WRITE the counter increments each cycle. On reaching TIMEOUT_CYC without a response:
  - Go to DONE and set mem_err.
  - IR/MDR are not updated.
- DONE: done=1 for one cycle, then IDLE.
  - Requests are ignored in DONE; the control unit advances on this edge and presents its next request in the following cycle.
- busy is combinational: 1 in READ/WRITE, and 1 in IDLE while mem_read|mem_write is high. It is 0 in DONE.
- address and m_wdata hold their latched values through DONE and while idle, and change only on acceptance.
- IR and MDR hold their contents between loads.
- mem_err is cleared only by reset.

## Timing
- Reset (async, immediate): state=IDLE, readM=0, writeM=0, address=0, m_wdata=0, instr=0, mdr=0, done=0, mem_err=0, counter=0. busy follows its combinational definition.
- Reset mid-access drops readM/writeM at once, without waiting for a clock edge. No partial IR/MDR update occurs.
- Latency, request edge to done, with the response arriving N cycles after the strobe rises (N≥1): N+2 cycles.
  - Cycle 0: accept.
  - Cycle 1: strobe high.
  - Cycle N: response sampled.
  - Cycle N+1: DONE.
- Minimum latency is 3 cycles.
- Back-to-back requests: at most one access every 3 cycles.
- inputReady or ackOutput arriving outside READ/WRITE respectively is ignored.
- A response on the same edge the counter hits TIMEOUT_CYC counts as success: data is captured and mem_err is unchanged.

## Structure
- Shared package (cpu_pkg): state enum for IDLE/READ/WRITE/DONE, WORD_W default.
- Sub-module mem_timeout_cnt: clear/enable counter with terminal-count output, parameterised by TIMEOUT_CYC.
- Everything else lives in a single FSM module.

## Test plan
- Fetch: pc=0x0010, mem_read=1, ir_write=1, iord=0; inputReady after 2 cycles with m_rdata=0xF01C -> address=0x0010, readM high 2 cycles, instr=0xF01C, mdr unchanged, done pulse 4 cycles after request.
- Load: iord=1, alu_out=0x0042, ir_write=0; m_rdata=0xBEEF -> address=0x0042, mdr=0xBEEF, instr unchanged.
- Store: mem_write=1, alu_out=0x0007, store_data=0x1234; ackOutput at first strobe cycle -> writeM for 1 cycle, m_wdata=0x1234, done 3 cycles after request.
- Timeout: TIMEOUT_CYC=4, read with no inputReady -> readM high 4 cycles, done pulse, mem_err=1, IR/MDR unchanged.
- Conflict and reset: mem_read=mem_write=1 -> read performed, writeM never high, mem_err=1. Then reset_n low during READ -> readM=0 without a clock edge, all outputs back to reset values.
